// File: rtl/bcd_add_sequencer.sv
// Multi-cycle packed-BCD adder: one 4-bit decimal digit per clock, LSD first.
// Define BCD_ADD_SEQ_ACCUM_EN to take operand B from the running SUM_BCD total (accumulate mode).
module bcd_add_sequencer #(
  parameter int NDIG = 2
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              CIN,
  input  logic [4*NDIG-1:0] A_BCD,
  input  logic [4*NDIG-1:0] B_BCD,
  output logic              BUSY,
  output logic              DONE,
  output logic [4*NDIG-1:0] SUM_BCD,
  output logic              COUT,
  output logic              ERR
);

  localparam int W    = 4 * NDIG;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_ADD,
    S_FINISH
  } state_t;

  state_t state, state_next;

  logic [W-1:0]    a_reg, b_reg, work_sum;
  logic            cin_reg, carry;
  logic [IDXW-1:0] idx;

  logic [3:0]   a_dig, b_dig, dig_out;
  logic [4:0]   dig_raw;
  logic         carry_next;
  logic [W-1:0] merged_sum;
  logic         operands_bad;
  logic         last_digit;

  assign last_digit = (idx == IDXW'(NDIG - 1));

  // Select the active digit pair and splice the corrected digit into the working sum.
  always_comb begin
    a_dig        = 4'd0;
    b_dig        = 4'd0;
    operands_bad = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (IDXW'(i) == idx) begin
        a_dig = a_reg[4*i +: 4];
        b_dig = b_reg[4*i +: 4];
      end
      if ((a_reg[4*i +: 4] > 4'd9) || (b_reg[4*i +: 4] > 4'd9)) begin
        operands_bad = 1'b1;
      end
    end
    dig_raw = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry};
    if (dig_raw > 5'd9) begin
      dig_out    = dig_raw[3:0] + 4'd6;
      carry_next = 1'b1;
    end else begin
      dig_out    = dig_raw[3:0];
      carry_next = 1'b0;
    end
    merged_sum = work_sum;
    for (int i = 0; i < NDIG; i++) begin
      if (IDXW'(i) == idx) begin
        merged_sum[4*i +: 4] = dig_out;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (START) state_next = S_CHECK;
      S_CHECK:  state_next = operands_bad ? S_FINISH : S_ADD;
      S_ADD:    if (last_digit) state_next = S_FINISH;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // BUSY/DONE are registered from the next state so they align with the state register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      SUM_BCD  <= '0;
      COUT     <= 1'b0;
      ERR      <= 1'b0;
      a_reg    <= '0;
      b_reg    <= '0;
      cin_reg  <= 1'b0;
      carry    <= 1'b0;
      idx      <= '0;
      work_sum <= '0;
    end else begin
      BUSY <= (state_next != S_IDLE);
      DONE <= (state_next == S_FINISH);
      case (state)
        S_IDLE: begin
          if (START) begin
            a_reg   <= A_BCD;
`ifdef BCD_ADD_SEQ_ACCUM_EN
            b_reg   <= SUM_BCD;
`else
            b_reg   <= B_BCD;
`endif
            cin_reg <= CIN;
          end
        end
        S_CHECK: begin
          idx      <= '0;
          carry    <= cin_reg;
          work_sum <= '0;
          if (operands_bad) begin
            SUM_BCD <= '0;
            COUT    <= 1'b0;
            ERR     <= 1'b1;
          end
        end
        S_ADD: begin
          work_sum <= merged_sum;
          carry    <= carry_next;
          idx      <= idx + IDXW'(1);
          if (last_digit) begin
            SUM_BCD <= merged_sum;
            COUT    <= carry_next;
            ERR     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_add_sequencer.sv
// Self-checking bench for bcd_add_sequencer: vector table, corner sequences, randomized ops vs decimal model.
// Follows the DUT build: with BCD_ADD_SEQ_ACCUM_EN defined, operand B is the running total.
module tb_bcd_add_sequencer;

  localparam int NDIG = 2;
  localparam int W    = 4 * NDIG;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  bcd_add_sequencer #(.NDIG(NDIG)) dut (
    .CLOCK_50(clk),
    .RESET_N (rst_n),
    .START   (start),
    .CIN     (cin),
    .A_BCD   (a),
    .B_BCD   (b),
    .BUSY    (busy),
    .DONE    (done),
    .SUM_BCD (sum),
    .COUT    (cout),
    .ERR     (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         poke;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_err;
  } vec_t;

  int checks = 0;
  int fails = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_cout = 1'b0;
  logic         last_err = 1'b0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Decimal reference model: operands are read as integers, added, and re-encoded.
  function automatic int bcd_to_int(input logic [W-1:0] v);
    int r = 0;
    for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < NDIG; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit has_bad_digit(input logic [W-1:0] v);
    for (int i = 0; i < NDIG; i++) if (v[4*i +: 4] > 4'd9) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                          output logic [W-1:0] es, output logic ec, output logic ee);
    logic [W-1:0] b_eff;
    int limit = 1;
    int total;
    for (int i = 0; i < NDIG; i++) limit = limit * 10;
`ifdef BCD_ADD_SEQ_ACCUM_EN
    b_eff = last_sum;
`else
    b_eff = bv;
`endif
    if (has_bad_digit(av) || has_bad_digit(b_eff)) begin
      es = '0; ec = 1'b0; ee = 1'b1;
    end else begin
      total = bcd_to_int(av) + bcd_to_int(b_eff) + int'(cv);
      es = int_to_bcd(total % limit);
      ec = (total >= limit);
      ee = 1'b0;
    end
  endtask

  // One START pulse, then watch BUSY, output hold, DONE latency and the result.
  task automatic apply_stimulus(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                                input logic cv, input logic poke, input logic [W-1:0] es,
                                input logic ec, input logic ee);
    int k = 0;
    bit got = 0;
    int exp_lat = ee ? 1 : NDIG + 1;
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    while (k < NDIG + 8 && !got) begin
      @(negedge clk);
      if (k == 0) begin
        check_output({name, " busy"}, 32'(busy), 32'd1);
        if (poke) begin
          a = ~av; b = ~bv; cin = ~cv;
        end else begin
          start = 1'b0;
        end
      end
      if (k == 1) start = 1'b0;
      if (done) begin
        got = 1;
        check_output({name, " latency"}, 32'(k), 32'(exp_lat));
        check_output({name, " sum"}, 32'(sum), 32'(es));
        check_output({name, " cout"}, 32'(cout), 32'(ec));
        check_output({name, " err"}, 32'(err), 32'(ee));
      end else begin
        check_output({name, " hold"}, 32'({last_err, last_cout, sum}), 32'({last_err, last_cout, last_sum}));
        check_output({name, " hold flags"}, 32'({err, cout}), 32'({last_err, last_cout}));
      end
      k++;
    end
    if (!got) check_output({name, " done timeout"}, 32'd0, 32'd1);
    @(negedge clk);
    check_output({name, " idle after"}, 32'({busy, done}), 32'd0);
    last_sum = es; last_cout = ec; last_err = ee;
  endtask

  vec_t vecs[$];
  logic [W-1:0] es, ra, rb;
  logic ec, ee, rc;
  int pulses[$];

  initial begin
`ifdef BCD_ADD_SEQ_ACCUM_EN
    vecs.push_back('{8'h25, 8'h99, 1'b0, 1'b0, 8'h25, 1'b0, 1'b0});
    vecs.push_back('{8'h25, 8'h11, 1'b0, 1'b0, 8'h50, 1'b0, 1'b0});
    vecs.push_back('{8'h60, 8'h00, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0});
    vecs.push_back('{8'h3A, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'h07, 8'h88, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0});
`else
    vecs.push_back('{8'h47, 8'h38, 1'b0, 1'b0, 8'h85, 1'b0, 1'b0});
    vecs.push_back('{8'h99, 8'h99, 1'b1, 1'b0, 8'h99, 1'b1, 1'b0});
    vecs.push_back('{8'h3A, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0});
    vecs.push_back('{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0});
    vecs.push_back('{8'h50, 8'h50, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    vecs.push_back('{8'h12, 8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{8'h47, 8'h38, 1'b0, 1'b0, 8'h85, 1'b0, 1'b0});
`endif

    #1;
    check_output("reset outputs", 32'({busy, done, cout, err, sum}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      apply_stimulus($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].poke,
                     vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_err);
    end

`ifndef BCD_ADD_SEQ_ACCUM_EN
    // START held high: DONE must pulse once per minimum period.
    @(negedge clk);
    a = 8'h11; b = 8'h22; cin = 1'b0; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done) begin
        pulses.push_back(c);
        check_output("held sum", 32'(sum), 32'h33);
      end
    end
    start = 1'b0;
    check_output("held pulse count", 32'(pulses.size() >= 5), 32'd1);
    for (int i = 1; i < pulses.size(); i++) begin
      check_output("held period", 32'(pulses[i] - pulses[i-1]), 32'(NDIG + 3));
    end
    repeat (NDIG + 3) @(negedge clk);
    last_sum = 8'h33; last_cout = 1'b0; last_err = 1'b0;
`endif

    // Reset asserted in the middle of ADD clears every output without a clock.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_output("async reset", 32'({busy, done, cout, err, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_sum = '0; last_cout = 1'b0; last_err = 1'b0;
    model_op(8'h05, 8'h05, 1'b0, es, ec, ee);
    apply_stimulus("post reset", 8'h05, 8'h05, 1'b0, 1'b0, es, ec, ee);

    for (int n = 0; n < 25; n++) begin
      for (int d = 0; d < NDIG; d++) begin
        ra[4*d +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        rb[4*d +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      end
      rc = 1'($urandom_range(0, 1));
      model_op(ra, rb, rc, es, ec, ee);
      apply_stimulus($sformatf("rand%0d", n), ra, rb, rc, 1'($urandom_range(0, 1)), es, ec, ee);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
